// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC sequencer: data widths, FSM state
// encodings and a small stall-decode helper.
package fetch_pc_unit_pkg;

    // Pipeline address/data width (matches opcodes.v)
    localparam int unsigned WORD_SIZE = 16;
    // Performance counter width
    localparam int unsigned CNT_W     = 16;
    // Redirect bubble counter width (holds 0..3)
    localparam int unsigned BUB_W     = 2;

    typedef enum logic [1:0] {
        FETCH_BOOT   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_BUBBLE = 2'd2,
        FETCH_HALT   = 2'd3
    } fetch_state_e;

    // Any hazard or memory back-pressure that holds the PC in RUN
    function automatic logic fetch_any_stall(
        input logic pc_stall,
        input logic branch_stall,
        input logic imem_ready
    );
        return pc_stall | branch_stall | ~imem_ready;
    endfunction

endpackage

// File: rtl/fetch_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Ports:
//   clk    - clock
//   clr_n  - asynchronous active-low clear
//   en     - count enable; count holds once all ones
//   count  - current count
module fetch_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Increment unless already saturated
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter register and fetch sequencer. Selects the next fetch
// address from halt, branch redirect, jump redirect, stall or the branch
// predictor, and raises the IF-flush pulse on redirects.
// Build option: define FETCH_PERF_CNT_EN to enable the redirect/stall
// performance counters; otherwise both counter ports read 16'h0000.
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   pred_next_pc                - predictor next_PC for the current pc
//   pc_stall, branch_stall      - hazard stalls
//   imem_ready                  - instruction memory accepts fetch
//   redirect_valid/redirect_pc  - resolved branch mispredict and target
//   jump_valid/jump_pc          - decoded jump and target
//   halt                        - HLT reached ID
//   pc                          - current fetch address
//   fetch_req                   - fetch at pc is valid
//   if_flush                    - squash IF/ID instruction (one-cycle pulse)
//   halted                      - sequencer stopped
//   redirect_count, stall_count - performance counters
module fetch_pc_unit #(
    parameter int unsigned          WORD_SIZE        = fetch_pc_unit_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC         = '0,
    parameter int unsigned          REDIRECT_BUBBLES = 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [WORD_SIZE-1:0]                 pred_next_pc,
    input  logic                                 pc_stall,
    input  logic                                 branch_stall,
    input  logic                                 imem_ready,
    input  logic                                 redirect_valid,
    input  logic [WORD_SIZE-1:0]                 redirect_pc,
    input  logic                                 jump_valid,
    input  logic [WORD_SIZE-1:0]                 jump_pc,
    input  logic                                 halt,
    output logic [WORD_SIZE-1:0]                 pc,
    output logic                                 fetch_req,
    output logic                                 if_flush,
    output logic                                 halted,
    output logic [fetch_pc_unit_pkg::CNT_W-1:0]  redirect_count,
    output logic [fetch_pc_unit_pkg::CNT_W-1:0]  stall_count
);
    import fetch_pc_unit_pkg::*;

    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [WORD_SIZE-1:0] pc_d;
    logic                 flush_d;
    logic [BUB_W-1:0]     bub_q;
    logic [BUB_W-1:0]     bub_d;
    logic                 redirect_inc;
    logic                 stall_inc;

    // State, PC and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH_BOOT;
            pc        <= RESET_PC;
            if_flush  <= 1'b0;
            bub_q     <= '0;
            fetch_req <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            if_flush  <= flush_d;
            bub_q     <= bub_d;
            fetch_req <= (state_d == FETCH_RUN);
            halted    <= (state_d == FETCH_HALT);
        end
    end

    // Next-state and next-PC selection; halt > redirect > jump > stall > predictor
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        flush_d      = 1'b0;
        bub_d        = bub_q;
        redirect_inc = 1'b0;
        stall_inc    = 1'b0;

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end

            FETCH_RUN: begin
                if (halt) begin
                    state_d = FETCH_HALT;
                end else if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    flush_d      = 1'b1;
                    bub_d        = BUB_LOAD;
                    redirect_inc = 1'b1;
                    if (BUB_LOAD != '0) begin
                        state_d = FETCH_BUBBLE;
                    end
                end else if (jump_valid) begin
                    pc_d         = jump_pc;
                    flush_d      = 1'b1;
                    redirect_inc = 1'b1;
                end else if (fetch_any_stall(pc_stall, branch_stall, imem_ready)) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_d = pred_next_pc;
                end
            end

            FETCH_BUBBLE: begin
                // Jumps and stalls are ignored while the pipe refills
                if (halt) begin
                    state_d = FETCH_HALT;
                end else if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    flush_d      = 1'b1;
                    bub_d        = BUB_LOAD;
                    redirect_inc = 1'b1;
                end else if (bub_q <= BUB_W'(1)) begin
                    state_d = FETCH_RUN;
                    bub_d   = '0;
                end else begin
                    bub_d = bub_q - BUB_W'(1);
                end
            end

            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    // Accepted redirects (branch and jump)
    fetch_sat_counter #(
        .WIDTH (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (redirect_inc),
        .count (redirect_count)
    );

    // RUN cycles held by a stall
    fetch_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (stall_inc),
        .count (stall_count)
    );
`else
    logic unused_perf;
    assign unused_perf    = redirect_inc ^ stall_inc;
    assign redirect_count = '0;
    assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: per-scenario stimulus rows drive the
// DUT, expected observations go through a scoreboard queue and are compared
// one cycle later.
module tb_fetch_pc_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        rv;
        logic [15:0] rpc;
        logic        jv;
        logic [15:0] jpc;
        logic        ps;
        logic        bs;
        logic        nr;
        logic        hl;
        logic        ov;
        logic [15:0] ovv;
    } stim_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        fr;
        logic        fl;
        logic        hd;
        logic [15:0] rc;
        logic [15:0] sc;
    } obs_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] pred_next_pc;
    logic        pc_stall;
    logic        branch_stall;
    logic        imem_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        jump_valid;
    logic [15:0] jump_pc;
    logic        halt;
    logic [15:0] pc;
    logic        fetch_req;
    logic        if_flush;
    logic        halted;
    logic [15:0] redirect_count;
    logic [15:0] stall_count;

    logic        ov;
    logic [15:0] ovv;

    int   n_run;
    int   n_fail;
    obs_t sb[$];

    fetch_pc_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pred_next_pc   (pred_next_pc),
        .pc_stall       (pc_stall),
        .branch_stall   (branch_stall),
        .imem_ready     (imem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .jump_valid     (jump_valid),
        .jump_pc        (jump_pc),
        .halt           (halt),
        .pc             (pc),
        .fetch_req      (fetch_req),
        .if_flush       (if_flush),
        .halted         (halted),
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predictor stand-in: sequential fetch unless a test overrides it
    always_comb pred_next_pc = ov ? ovv : pc + 16'd1;

    function automatic stim_t mk_st(input logic rv, input logic [15:0] rpc,
                                    input logic jv, input logic [15:0] jpc,
                                    input logic ps, input logic bs, input logic nr,
                                    input logic hl, input logic ov_i, input logic [15:0] ovv_i);
        stim_t s;
        s.rv = rv; s.rpc = rpc; s.jv = jv; s.jpc = jpc; s.ps = ps; s.bs = bs;
        s.nr = nr; s.hl = hl; s.ov = ov_i; s.ovv = ovv_i;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk_st(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    endfunction

    function automatic obs_t mk_ob(input logic [15:0] p, input logic fr, input logic fl,
                                   input logic hd, input int rc, input int sc);
        obs_t o;
        o.pc = p; o.fr = fr; o.fl = fl; o.hd = hd;
        o.rc = PERF ? 16'(rc) : 16'h0;
        o.sc = PERF ? 16'(sc) : 16'h0;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc = pc; o.fr = fetch_req; o.fl = if_flush; o.hd = halted;
        o.rc = redirect_count; o.sc = stall_count;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h fetch_req=%b if_flush=%b halted=%b rc=%0d sc=%0d",
                         o.pc, o.fr, o.fl, o.hd, o.rc, o.sc);
    endfunction

    task automatic apply(input stim_t s);
        redirect_valid = s.rv; redirect_pc = s.rpc;
        jump_valid = s.jv; jump_pc = s.jpc;
        pc_stall = s.ps; branch_stall = s.bs; imem_ready = ~s.nr;
        halt = s.hl; ov = s.ov; ovv = s.ovv;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        apply(idle());
        reset_n = 1'b0;
        #2;
        got = observe(); e = mk_ob(16'h0000, 0, 0, 0, 0, 0);
        n_run++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %s required %s", fmt(got), fmt(e));
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        st.push_back(idle()); ex.push_back(mk_ob(16'h0000, 1, 0, 0, 0, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0001, 1, 0, 0, 0, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0002, 1, 0, 0, 0, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0003, 1, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL boot[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_redirect();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0010));
        ex.push_back(mk_ob(16'h0010, 1, 0, 0, 0, 0));
        st.push_back(mk_st(1, 16'h0040, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0040, 0, 1, 0, 1, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0040, 1, 0, 0, 1, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0041, 1, 0, 0, 1, 0));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL redirect[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        // redirect beats jump and stall
        st.push_back(mk_st(1, 16'h0040, 1, 16'h0080, 1, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0040, 0, 1, 0, 2, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0040, 1, 0, 0, 2, 0));
        // jump beats branch stall, stays in RUN
        st.push_back(mk_st(0, 16'h0, 1, 16'h0080, 0, 1, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0080, 1, 1, 0, 3, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0081, 1, 0, 0, 3, 0));
        // jump beats imem back-pressure
        st.push_back(mk_st(0, 16'h0, 1, 16'h0090, 0, 0, 1, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0090, 1, 1, 0, 4, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0091, 1, 0, 0, 4, 0));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0005));
        ex.push_back(mk_ob(16'h0005, 1, 0, 0, 4, 0));
        for (int k = 1; k <= 3; k++) begin
            st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 1, 0, 0, 0, 16'h0));
            ex.push_back(mk_ob(16'h0005, 1, 0, 0, 4, k));
        end
        st.push_back(idle()); ex.push_back(mk_ob(16'h0006, 1, 0, 0, 4, 3));
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 0, 1, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0006, 1, 0, 0, 4, 4));
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0006, 1, 0, 0, 4, 5));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0007, 1, 0, 0, 4, 5));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_bubble();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        st.push_back(mk_st(1, 16'h0100, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0100, 0, 1, 0, 5, 5));
        // redirect during the bubble reloads pc and re-pulses flush
        st.push_back(mk_st(1, 16'h0200, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0200, 0, 1, 0, 6, 5));
        // jump and stalls ignored in the bubble
        st.push_back(mk_st(0, 16'h0, 1, 16'h0300, 1, 1, 1, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0200, 1, 0, 0, 6, 5));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0201, 1, 0, 0, 6, 5));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bubble[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, 16'hFFFF));
        ex.push_back(mk_ob(16'hFFFF, 1, 0, 0, 6, 5));
        st.push_back(mk_st(0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0000));
        ex.push_back(mk_ob(16'h0000, 1, 0, 0, 6, 5));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0001, 1, 0, 0, 6, 5));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_halt_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got;
        obs_t  e;
        st.push_back(mk_st(1, 16'h0040, 0, 16'h0, 0, 0, 0, 1, 0, 16'h0));
        ex.push_back(mk_ob(16'h0001, 0, 0, 1, 6, 5));
        st.push_back(mk_st(1, 16'h0050, 1, 16'h0060, 1, 0, 0, 0, 0, 16'h0));
        ex.push_back(mk_ob(16'h0001, 0, 0, 1, 6, 5));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0001, 0, 0, 1, 6, 5));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
        // asynchronous reset in the middle of a cycle
        #2;
        reset_n = 1'b0;
        #1;
        got = observe(); e = mk_ob(16'h0000, 0, 0, 0, 0, 0);
        n_run++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midcycle_reset: got %s required %s", fmt(got), fmt(e));
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        st.delete(); ex.delete();
        st.push_back(idle()); ex.push_back(mk_ob(16'h0000, 1, 0, 0, 0, 0));
        st.push_back(idle()); ex.push_back(mk_ob(16'h0001, 1, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            got = observe(); e = sb.pop_front(); n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL resume[%0d]: got %s required %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_redirect();
        test_priority();
        test_stall();
        test_bubble();
        test_wrap();
        test_halt_reset();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
